// File: rtl/if_ctrl_pkg.sv
// Shared fetch-stage definitions: reset PC, legal instruction-memory window,
// NOP word and the IF controller state encoding.
package if_ctrl_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_1000;
  localparam logic [31:0] IM_LO_BYTE = 32'h0000_1000;
  localparam logic [31:0] IM_HI_BYTE = 32'h0000_2FFC;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_RUN   = 2'd1,
    IF_FAULT = 2'd2
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Fetch PC register: loads the reset value, then on enable either steps by one
// word or takes a word-aligned redirect target.
module if_pc_reg
  import if_ctrl_pkg::*;
#(
  parameter logic [31:0] RST_VAL = RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = redirect ? word_align(target) : pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RST_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives instruction-memory
// address and the IF/ID register. Optional range check under IF_BOUNDS_CHECK_EN.
module if_ctrl
  import if_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        d_valid,
  output logic [31:0] fetch_cnt,
  output logic        fetch_fault
);

  if_state_e state_q, state_d;

  logic        pc_en, pc_redirect, ifid_load, ifid_bubble, set_fault, pc_oob;
  logic [31:0] ifid_ir_q, ifid_ir_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;

  if_pc_reg #(.RST_VAL(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .en       (pc_en),
    .redirect (pc_redirect),
    .target   (br_target),
    .pc       (pc_f)
  );

  assign im_addr = pc_f[12:2];

`ifdef IF_BOUNDS_CHECK_EN
  logic fault_q, fault_d;

  assign pc_oob = (pc_f < IM_LO_BYTE) || (pc_f > IM_HI_BYTE);

  always_comb begin
    fault_d = fault_q | set_fault;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign pc_oob      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IF_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_BOOT:  state_d = IF_RUN;
      IF_RUN:   if (!stall && pc_oob) state_d = IF_FAULT;
      IF_FAULT: if (!stall && br_taken) state_d = IF_RUN;
      default:  state_d = IF_BOOT;
    endcase
  end

  // Stall outranks a redirect; a redirect seen while faulting on the fetch is dropped.
  always_comb begin
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    set_fault   = 1'b0;
    unique case (state_q)
      IF_RUN: begin
        if (!stall) begin
          if (pc_oob) begin
            ifid_bubble = 1'b1;
            set_fault   = 1'b1;
          end else begin
            pc_en       = 1'b1;
            pc_redirect = br_taken;
            ifid_load   = 1'b1;
          end
        end
      end
      IF_FAULT: begin
        if (!stall && br_taken) begin
          pc_en       = 1'b1;
          pc_redirect = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ifid_ir_d = ifid_ir_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    if (ifid_load) begin
      ifid_ir_d = im_data;
      ifid_pc_d = pc_f;
      valid_d   = 1'b1;
      cnt_d     = cnt_q + 32'd1;
    end else if (ifid_bubble) begin
      ifid_ir_d = NOP_WORD;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_ir_q <= NOP_WORD;
      ifid_pc_q <= 32'd0;
      valid_q   <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      ifid_ir_q <= ifid_ir_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ir_d      = ifid_ir_q;
  assign pc_d      = ifid_pc_q;
  assign pc8_d     = ifid_pc_q + 32'd8;
  assign d_valid   = valid_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_ctrl.sv
// Self-checking bench for if_ctrl: directed scenarios plus randomized traffic
// against a behavioural fetch model. Honors IF_BOUNDS_CHECK_EN.
module tb_if_ctrl;

`ifdef IF_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, br_taken;
  logic [31:0] br_target;
  logic [10:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] pc_f, ir_d, pc_d, pc8_d, fetch_cnt;
  logic        d_valid, fetch_fault;

  logic [31:0] mem [2048];

  int chk_count  = 0;
  int fail_count = 0;

  // Behavioural model of the fetch stage
  logic [31:0] m_pc, m_ir, m_pcd, m_cnt;
  logic        m_valid, m_fault;
  bit          m_boot, m_faulted;

  always #5 clk = ~clk;

  assign im_data = mem[im_addr];

  if_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .im_addr     (im_addr),
    .im_data     (im_data),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pc_f        (pc_f),
    .ir_d        (ir_d),
    .pc_d        (pc_d),
    .pc8_d       (pc8_d),
    .d_valid     (d_valid),
    .fetch_cnt   (fetch_cnt),
    .fetch_fault (fetch_fault)
  );

  task automatic model_step(input bit rst, input bit st, input bit br, input logic [31:0] tgt);
    logic [31:0] aligned;
    aligned = tgt & 32'hFFFF_FFFC;
    if (rst) begin
      m_pc = 32'h1000; m_ir = 0; m_pcd = 0; m_valid = 0; m_cnt = 0; m_fault = 0;
      m_boot = 1; m_faulted = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (st) begin
    end else if (m_faulted) begin
      if (br) begin
        m_pc = aligned;
        m_faulted = 0;
      end
    end else if (CHK && (m_pc < 32'h1000 || m_pc > 32'h2FFC)) begin
      m_ir = 0; m_valid = 0; m_fault = 1; m_faulted = 1;
    end else begin
      m_ir    = mem[(m_pc >> 2) % 2048];
      m_pcd   = m_pc;
      m_valid = 1;
      m_cnt   = m_cnt + 1;
      m_pc    = br ? aligned : m_pc + 4;
    end
  endtask

  task automatic tick(input bit rst, input bit st, input bit br, input logic [31:0] tgt);
    reset = rst; stall = st; br_taken = br; br_target = tgt;
    model_step(rst, st, br, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0);
    tick(1, 1, 1, 32'h1234);
    chk_count++; if (pc_f !== 32'h1000) begin fail_count++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc_f, 32'h1000); end
    chk_count++; if (d_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_valid got=%b exp=0", d_valid); end
    chk_count++; if (fetch_cnt !== 32'd0) begin fail_count++; $display("[TB] FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
    chk_count++; if (ir_d !== 32'd0 || pc_d !== 32'd0) begin fail_count++; $display("[TB] FAIL reset_ifid got ir=%h pc=%h exp 0/0", ir_d, pc_d); end
    chk_count++; if (fetch_fault !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_fault got=%b exp=0", fetch_fault); end
    tick(0, 1, 1, 32'h1800);
    chk_count++; if (d_valid !== 1'b0 || pc_f !== 32'h1000) begin fail_count++; $display("[TB] FAIL boot_cycle got valid=%b pc=%h exp 0/1000", d_valid, pc_f); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      chk_count++; if (pc_d !== 32'h1000 + 4*i) begin fail_count++; $display("[TB] FAIL seq_pc_d[%0d] got=%h exp=%h", i, pc_d, 32'h1000 + 4*i); end
      chk_count++; if (ir_d !== mem[1024 + i] || d_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL seq_ir[%0d] got=%h/%b exp=%h/1", i, ir_d, d_valid, mem[1024 + i]); end
      if (i == 0) begin
        chk_count++; if (pc8_d !== 32'h1008) begin fail_count++; $display("[TB] FAIL seq_pc8 got=%h exp=1008", pc8_d); end
      end
    end
    chk_count++; if (fetch_cnt !== 32'd3) begin fail_count++; $display("[TB] FAIL seq_cnt got=%0d exp=3", fetch_cnt); end
  endtask

  task automatic test_redirect();
    tick(0, 0, 0, 0);
    chk_count++; if (pc_f !== 32'h1010) begin fail_count++; $display("[TB] FAIL redir_setup got=%h exp=1010", pc_f); end
    tick(0, 0, 1, 32'h1200);
    chk_count++; if (pc_d !== 32'h1010 || d_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL delay_slot got pc_d=%h valid=%b exp 1010/1", pc_d, d_valid); end
    chk_count++; if (pc_f !== 32'h1200) begin fail_count++; $display("[TB] FAIL redir_pc got=%h exp=1200", pc_f); end
    tick(0, 0, 0, 0);
    chk_count++; if (pc_d !== 32'h1200 || ir_d !== mem[32'h1200 >> 2]) begin fail_count++; $display("[TB] FAIL redir_fetch got pc_d=%h ir=%h exp 1200/%h", pc_d, ir_d, mem[32'h1200 >> 2]); end
  endtask

  task automatic test_stall();
    tick(0, 0, 1, 32'h1020);
    chk_count++; if (pc_f !== 32'h1020) begin fail_count++; $display("[TB] FAIL stall_setup got=%h exp=1020", pc_f); end
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1, 32'h1300);
      chk_count++;
      if (pc_f !== 32'h1020 || ir_d !== mem[32'h1204 >> 2] || fetch_cnt !== 32'd7) begin
        fail_count++;
        $display("[TB] FAIL stall_hold[%0d] got pc=%h ir=%h cnt=%0d exp 1020/%h/7", i, pc_f, ir_d, fetch_cnt, mem[32'h1204 >> 2]);
      end
    end
    tick(0, 0, 1, 32'h1300);
    chk_count++; if (pc_f !== 32'h1300 || pc_d !== 32'h1020 || fetch_cnt !== 32'd8) begin fail_count++; $display("[TB] FAIL stall_release got pc=%h pc_d=%h cnt=%0d exp 1300/1020/8", pc_f, pc_d, fetch_cnt); end
  endtask

  task automatic test_mid_reset();
    tick(0, 0, 1, 32'h1400);
    tick(1, 1, 1, 32'h1500);
    chk_count++; if (pc_f !== 32'h1000 || d_valid !== 1'b0 || fetch_cnt !== 32'd0) begin fail_count++; $display("[TB] FAIL mid_reset got pc=%h valid=%b cnt=%0d exp 1000/0/0", pc_f, d_valid, fetch_cnt); end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk_count++; if (pc_d !== 32'h1000 || fetch_cnt !== 32'd1) begin fail_count++; $display("[TB] FAIL post_reset got pc_d=%h cnt=%0d exp 1000/1", pc_d, fetch_cnt); end
  endtask

  task automatic test_boundary();
    tick(0, 0, 1, 32'h2FFE);
    chk_count++; if (pc_f !== 32'h2FFC || im_addr !== 11'h3FF) begin fail_count++; $display("[TB] FAIL bound_last got pc=%h addr=%h exp 2ffc/3ff", pc_f, im_addr); end
    tick(0, 0, 0, 0);
    chk_count++; if (pc_d !== 32'h2FFC || d_valid !== 1'b1 || ir_d !== mem[11'h3FF]) begin fail_count++; $display("[TB] FAIL bound_fetch got pc_d=%h valid=%b ir=%h exp 2ffc/1/%h", pc_d, d_valid, ir_d, mem[11'h3FF]); end
    chk_count++; if (pc_f !== 32'h3000 || im_addr !== 11'h400) begin fail_count++; $display("[TB] FAIL bound_next got pc=%h addr=%h exp 3000/400", pc_f, im_addr); end
    tick(0, 0, 1, 32'h1800);
`ifdef IF_BOUNDS_CHECK_EN
    chk_count++; if (fetch_fault !== 1'b1 || d_valid !== 1'b0 || ir_d !== 32'd0 || pc_f !== 32'h3000) begin fail_count++; $display("[TB] FAIL fault_entry got fault=%b valid=%b ir=%h pc=%h exp 1/0/0/3000", fetch_fault, d_valid, ir_d, pc_f); end
    tick(0, 0, 0, 0);
    chk_count++; if (pc_f !== 32'h3000 || d_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL fault_hold got pc=%h valid=%b exp 3000/0", pc_f, d_valid); end
    tick(0, 0, 1, 32'h1100);
    chk_count++; if (pc_f !== 32'h1100 || fetch_fault !== 1'b1) begin fail_count++; $display("[TB] FAIL fault_exit got pc=%h fault=%b exp 1100/1", pc_f, fetch_fault); end
    tick(0, 0, 0, 0);
    chk_count++; if (pc_d !== 32'h1100 || d_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL fault_resume got pc_d=%h valid=%b exp 1100/1", pc_d, d_valid); end
`else
    chk_count++; if (pc_d !== 32'h3000 || d_valid !== 1'b1 || ir_d !== mem[11'h400] || fetch_fault !== 1'b0) begin fail_count++; $display("[TB] FAIL bound_wrap got pc_d=%h valid=%b ir=%h fault=%b exp 3000/1/%h/0", pc_d, d_valid, ir_d, fetch_fault, mem[11'h400]); end
    chk_count++; if (pc_f !== 32'h1800) begin fail_count++; $display("[TB] FAIL bound_redir got pc=%h exp 1800", pc_f); end
`endif
  endtask

  task automatic test_random();
    bit          rst, st, br;
    logic [31:0] tgt;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 4) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(32'h1000, 32'h2FFF);
      tick(rst, st, br, tgt);
      chk_count++;
      if (pc_f !== m_pc || ir_d !== m_ir || pc_d !== m_pcd || pc8_d !== m_pcd + 32'd8 ||
          d_valid !== m_valid || fetch_cnt !== m_cnt || fetch_fault !== m_fault || im_addr !== m_pc[12:2]) begin
        fail_count++;
        $display("[TB] FAIL random[%0d] got pc=%h ir=%h pc_d=%h pc8=%h v=%b cnt=%0d f=%b exp pc=%h ir=%h pc_d=%h v=%b cnt=%0d f=%b",
                 i, pc_f, ir_d, pc_d, pc8_d, d_valid, fetch_cnt, fetch_fault, m_pc, m_ir, m_pcd, m_valid, m_cnt, m_fault);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = $urandom();
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_mid_reset();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
    $finish;
  end

endmodule
